// File: rtl/vga3_pkg.sv
// ---------------------------------------------------------------------------
// vga3_pkg
// Shared definitions for the VGA3 video path:
//   - AWIDTH_DEF / DWIDTH_DEF : default SRAM address / data widths
//   - wrq_state_t             : 2-bit state encoding of the VRAM write FSM
// ---------------------------------------------------------------------------
package vga3_pkg;

  localparam int AWIDTH_DEF = 18;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wrq_state_t;

endpackage

// File: rtl/vram_wr_queue_if.sv
// ---------------------------------------------------------------------------
// vram_wr_queue_if
// Bundles the pixel-request side and the SRAM write side of vram_wr_queue.
//   Request : DataStbIn, AddrIn, DataIn, WrSlotIn
//   SRAM    : SramAddrOut, SramDataOut, WeOut
//   Status  : BusyOut, FullOut, EmptyOut, OverflowCntOut
// Modports: slave = the queue itself, master = whoever drives requests.
// ---------------------------------------------------------------------------
interface vram_wr_queue_if #(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8
);
  logic              DataStbIn;
  logic [AWIDTH-1:0] AddrIn;
  logic [DWIDTH-1:0] DataIn;
  logic              WrSlotIn;
  logic [AWIDTH-1:0] SramAddrOut;
  logic [DWIDTH-1:0] SramDataOut;
  logic              WeOut;
  logic              BusyOut;
  logic              FullOut;
  logic              EmptyOut;
  logic [7:0]        OverflowCntOut;

  modport slave (
    input  DataStbIn, AddrIn, DataIn, WrSlotIn,
    output SramAddrOut, SramDataOut, WeOut, BusyOut, FullOut, EmptyOut,
           OverflowCntOut
  );

  modport master (
    output DataStbIn, AddrIn, DataIn, WrSlotIn,
    input  SramAddrOut, SramDataOut, WeOut, BusyOut, FullOut, EmptyOut,
           OverflowCntOut
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// ---------------------------------------------------------------------------
// vram_wr_fifo
// Synchronous FIFO with registered full/empty flags.
//   clk, srst : clock, synchronous active-high reset
//   i_push    : push request (accepted if not full, or full with a pop)
//   i_pop     : pop request (ignored while empty)
//   i_data    : entry to push
//   o_data    : current head entry (valid while o_empty=0)
//   o_full    : occupancy == DEPTH after this edge's push/pop
//   o_empty   : occupancy == 0 after this edge's push/pop
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module vram_wr_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PW:0]      w_count_next;

  // A push into a full queue still fits when the head leaves on the same edge.
  assign w_push_ok    = i_push & (~r_full | i_pop);
  assign w_pop_ok     = i_pop & ~r_empty;
  assign w_count_next = r_count + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop_ok};

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!srst && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (PW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/vram_wr_queue.sv
// ---------------------------------------------------------------------------
// vram_wr_queue
// Buffers pixel write requests and replays them into the VRAM SRAM during
// write slots granted by the display scanner. Each write runs
// SETUP (1 clk) -> STROBE (WE_CYCLES clks, WeOut=1) -> HOLD (1 clk).
//   ClkIn  : system clock, rising edge
//   RstIn  : synchronous active-high reset
//   bus    : vram_wr_queue_if.slave (requests in, SRAM write port and
//            status out)
// Optional feature: define VRAM_WR_QUEUE_OVFCNT_EN to count dropped
// requests on OverflowCntOut (saturating at 255); otherwise it reads 0.
// ---------------------------------------------------------------------------
module vram_wr_queue
  import vga3_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int DEPTH     = 16,
  parameter int WE_CYCLES = 2
) (
  input  logic            ClkIn,
  input  logic            RstIn,
  vram_wr_queue_if.slave  bus
);
  localparam int EW = AWIDTH + DWIDTH;
  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  wrq_state_t        r_state;
  logic              r_we;
  logic              r_busy;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;
  logic [CW-1:0]     r_we_cnt;

  logic [EW-1:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  // Pop only from IDLE, and only while the scanner grants the slot.
  assign w_pop = (r_state == ST_IDLE) & ~w_empty & bus.WrSlotIn;

  vram_wr_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ClkIn),
    .srst    (RstIn),
    .i_push  (bus.DataStbIn),
    .i_pop   (w_pop),
    .i_data  ({bus.AddrIn, bus.DataIn}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The SRAM address/data registers load only on the IDLE->SETUP edge, so
  // they stay stable through the whole write and after it.
  always_ff @(posedge ClkIn) begin
    if (RstIn) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_addr  <= w_head[DWIDTH +: AWIDTH];
            r_data  <= w_head[DWIDTH-1:0];
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_we     <= 1'b1;
          r_we_cnt <= CW'(WE_CYCLES - 1);
          r_state  <= ST_STROBE;
        end
        ST_STROBE: begin
          // WrSlotIn is deliberately ignored here: a started write finishes.
          if (r_we_cnt == '0) begin
            r_we    <= 1'b0;
            r_state <= ST_HOLD;
          end else begin
            r_we_cnt <= r_we_cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VRAM_WR_QUEUE_OVFCNT_EN
  logic       w_drop;
  logic [7:0] r_ovf_cnt;

  // A request is lost only when the queue is full and nothing leaves.
  assign w_drop = bus.DataStbIn & w_full & ~w_pop;

  always_ff @(posedge ClkIn) begin
    if (RstIn) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign bus.OverflowCntOut = r_ovf_cnt;
`else
  assign bus.OverflowCntOut = '0;
`endif

  assign bus.SramAddrOut = r_addr;
  assign bus.SramDataOut = r_data;
  assign bus.WeOut       = r_we;
  assign bus.BusyOut     = r_busy;
  assign bus.FullOut     = w_full;
  assign bus.EmptyOut    = w_empty;
endmodule

// File: doc/vram_wr_queue.md
VRAM_WR_QUEUE -- requirements
Module: vram_wr_queue

Interface
REQ-001 Parameter AWIDTH, default 18, SRAM address width.
REQ-002 Parameter DWIDTH, default 8, SRAM data width.
REQ-003 Parameter DEPTH, default 16, queue entries, power of two, minimum 2.
REQ-004 Parameter WE_CYCLES, default 2, clocks WeOut is held high per write, minimum 1.
REQ-005 ClkIn  in  1  single system clock; all logic on rising edge.
REQ-006 RstIn  in  1  synchronous, active-high reset.
REQ-007 DataStbIn  in  1  one-cycle pulse, ClkIn domain: pixel write request.
REQ-008 AddrIn  in  AWIDTH  write address from the command receiver, valid with DataStbIn.
REQ-009 DataIn  in  DWIDTH  pixel byte, valid with DataStbIn.
REQ-010 WrSlotIn  in  1  high while the display scanner leaves the SRAM free for writes.
REQ-011 SramAddrOut  out  AWIDTH  SRAM address.
REQ-012 SramDataOut  out  DWIDTH  SRAM write data.
REQ-013 WeOut  out  1  SRAM write enable, active high.
REQ-014 BusyOut  out  1  high whenever the FSM is not in IDLE.
REQ-015 FullOut / EmptyOut  out  1 each  queue status, registered.
REQ-016 OverflowCntOut  out  8  dropped-request count (see Configuration).

Function
REQ-017 Queue entry SHALL be {AddrIn, DataIn}, captured on the edge where DataStbIn=1.
REQ-018 Push SHALL be accepted when FullOut=0, or when FullOut=1 and a pop occurs on the same edge; otherwise the request is dropped and the queue is unchanged.
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-020 IDLE -> SETUP when EmptyOut=0 and WrSlotIn=1; on that edge the head entry SHALL be popped into SramAddrOut/SramDataOut.
REQ-021 SETUP: WeOut=0, address/data stable, exactly 1 cycle, then STROBE.
REQ-022 STROBE: WeOut=1 for exactly WE_CYCLES cycles, then HOLD.
REQ-023 HOLD: WeOut=0, address/data unchanged, exactly 1 cycle, then IDLE.
REQ-024 A write SHALL occupy WE_CYCLES+2 cycles from pop to return to IDLE; back-to-back writes SHALL add one IDLE cycle between writes.
REQ-025 WrSlotIn falling after a pop SHALL NOT abort the write; it SHALL complete through HOLD. No new pop while WrSlotIn=0.
REQ-026 SramAddrOut/SramDataOut SHALL change only on the IDLE->SETUP edge.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width is log2(DEPTH)+1.
REQ-028 First-request latency: DataStbIn into an empty queue with WrSlotIn=1 -> pop on the 2nd following edge, WeOut high 2 cycles after the pop.
REQ-029 FullOut/EmptyOut SHALL reflect occupancy after the current edge's push and pop.

Reset
REQ-030 RstIn=1 on a rising edge SHALL force IDLE, empty queue, WeOut=0, SramAddrOut=0, SramDataOut=0, BusyOut=0, EmptyOut=1, FullOut=0, OverflowCntOut=0.
REQ-031 Reset during STROBE SHALL drop WeOut on the same edge; the in-flight entry and all queued entries are discarded.
REQ-032 DataStbIn while RstIn=1 SHALL be ignored.

Configuration
REQ-033 Macro VRAM_WR_QUEUE_OVFCNT_EN defined: OverflowCntOut increments by 1 on each dropped request (REQ-018), saturating at 255, cleared only by reset.
REQ-034 Macro undefined: OverflowCntOut SHALL be tied to 0 and no counter logic synthesised; port list identical.

Structure
REQ-035 Shared package vga3_pkg SHALL hold the FSM state encoding (2-bit) and parameter defaults AWIDTH/DWIDTH.
REQ-036 Queue storage SHALL be a sub-module vram_wr_fifo (synchronous FIFO, registered flags, same clock/reset); FSM and overflow counter live in vram_wr_queue.

Verification
REQ-037 Single write: WrSlotIn=1, strobe Addr=0x12345 Data=0xA5 -> SramAddrOut=0x12345, SramDataOut=0xA5, WeOut high exactly 2 cycles, BusyOut low after HOLD.
REQ-038 Fill while WrSlotIn=0: 17 strobes Data=0..16 -> FullOut=1 after 16th, 17th dropped, OverflowCntOut=1 (macro on) / 0 (macro off); then WrSlotIn=1 -> 16 writes in order Data=0..15.
REQ-039 Push while full and pop same edge -> entry accepted, FullOut stays 1, OverflowCntOut unchanged.
REQ-040 WrSlotIn drops 1 cycle into STROBE -> write completes (WeOut 2 cycles), next queued entry waits until WrSlotIn=1.
REQ-041 RstIn pulsed during STROBE with 3 entries queued -> WeOut=0 next edge, EmptyOut=1, no further writes after reset releases.
REQ-042 Pointer wrap: 40 strobe/drain cycles with DEPTH=16 -> every address/data pair emerges once, in order.
